// File: rtl/ppm_framebuffer_stream.sv
// ppm_framebuffer_stream: MMIO RGB framebuffer with pixel write/read, whole-frame fill and raster-order byte dump
module ppm_framebuffer_stream #(
    parameter int FRAME_WIDTH  = 100,
    parameter int FRAME_HEIGHT = 100,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [2:0]            operation,
    output logic                  rd_valid,
    output logic [23:0]           rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           frame_count
);
    localparam int NPIX   = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int PIX_AW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam logic [PIX_AW-1:0]   LAST   = PIX_AW'(NPIX - 1);
    localparam logic [ADDR_WIDTH:0] NPIX_A = (ADDR_WIDTH + 1)'(NPIX);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILL    = 2'd1;
    localparam logic [1:0] DUMP_RD = 2'd2;
    localparam logic [1:0] DUMP_TX = 2'd3;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_FILL  = 3'd3;
    localparam logic [2:0] OP_DUMP  = 3'd4;

    logic [1:0]        state;
    logic [PIX_AW-1:0] p;
    logic [1:0]        b;
    logic [23:0]       pix;
    logic [23:0]       fill_val;
    logic [23:0]       mem [NPIX];
    logic [PIX_AW-1:0] a;
    logic              in_range;
    logic              take;
    logic              unused_data;

    // Range check uses the full address so high bits cannot alias into the frame
    assign a           = address[PIX_AW-1:0];
    assign in_range    = {1'b0, address} < NPIX_A;
    assign input_ready = state == IDLE;
    assign busy        = !input_ready;
    assign take        = input_valid && input_ready;
    assign out_valid   = state == DUMP_TX;
    assign out_last    = out_valid && b == 2'd2 && p == LAST;
    assign out_data    = !out_valid ? 8'h00 : b == 2'd0 ? pix[23:16] : b == 2'd1 ? pix[15:8] : pix[7:0];
    assign unused_data = ^data;

    // Pixel RAM write port: fill sweep or single WRITE, never both since they live in different states
    always_ff @(posedge clock) begin
        if (reset && state == FILL)
            mem[p] <= fill_val;
        else if (reset && take && operation == OP_WRITE && in_range)
            mem[a] <= data[23:0];
    end

    // Command decode, fill/dump sequencing, read results, error and frame bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            p           <= '0;
            b           <= '0;
            pix         <= '0;
            fill_val    <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err         <= 1'b0;
            frame_count <= '0;
        end else begin
            rd_valid <= take && operation == OP_READ;
            case (state)
                IDLE: if (take) begin
                    if ((operation == OP_WRITE || operation == OP_READ) && !in_range)
                        err <= 1'b1;
                    if (operation > OP_DUMP)
                        err <= 1'b1;
                    if (operation == OP_READ)
                        rd_data <= in_range ? mem[a] : 24'h0;
                    if (operation == OP_FILL) begin
                        fill_val <= data[23:0];
                        p        <= '0;
                        state    <= FILL;
                    end
                    if (operation == OP_DUMP) begin
                        p     <= '0;
                        state <= DUMP_RD;
                    end
                end
                FILL: begin
                    p     <= p + 1'b1;
                    state <= p == LAST ? IDLE : FILL;
                end
                DUMP_RD: begin
                    pix   <= mem[p];
                    b     <= '0;
                    state <= DUMP_TX;
                end
                default: if (out_ready) begin
                    if (b != 2'd2)
                        b <= b + 1'b1;
                    else if (p == LAST) begin
                        frame_count <= frame_count + 1'b1;
                        state       <= IDLE;
                    end else begin
                        p     <= p + 1'b1;
                        state <= DUMP_RD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ppm_framebuffer_stream.sv
// tb_ppm_framebuffer_stream: randomized self-checking bench against a frame-level reference model
module tb_ppm_framebuffer_stream;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clock = 0;
    logic        reset = 0;
    logic        input_valid = 0;
    logic        input_ready;
    logic [31:0] address = 0;
    logic [31:0] data = 0;
    logic [2:0]  operation = 0;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        out_valid;
    logic        out_ready = 1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        err;
    logic [15:0] frame_count;

    int          nvec = 0;
    int          nerr = 0;
    logic [23:0] model_mem [N];
    int          model_fc = 0;
    logic [7:0]  got_b [$];
    logic        got_l [$];

    ppm_framebuffer_stream #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
        .address(address), .data(data), .operation(operation), .rd_valid(rd_valid), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] ad, input logic [31:0] d, output int waited);
        input_valid = 1;
        operation = op;
        address = ad;
        data = d;
        waited = 0;
        while (!input_ready && waited < 1000) begin
            tick();
            waited++;
        end
        if (waited >= 1000) begin
            nvec++;
            nerr++;
            $display("FAIL cmd_timeout op=%0d input_ready stuck low, required high", op);
        end
        tick();
        input_valid = 0;
        operation = 0;
    endtask

    task automatic reset_dut();
        input_valid = 0;
        out_ready = 1;
        reset = 0;
        repeat (3) tick();
        reset = 1;
        tick();
        model_fc = 0;
    endtask

    task automatic run_dump(input bit stall, output int busy_cyc);
        logic [7:0] pd;
        logic       pl;
        bit         ps;
        int         cyc;
        int         w;
        got_b.delete();
        got_l.delete();
        send_cmd(3'd4, 0, 0, w);
        ps = 0;
        pd = 0;
        pl = 0;
        busy_cyc = 0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            busy_cyc++;
            cyc++;
            if (ps) begin
                nvec++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    nerr++;
                    $display("FAIL stall_hold got v=%b d=%h l=%b, required v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
                end
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_b.push_back(out_data);
                got_l.push_back(out_last);
            end
            ps = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            tick();
        end
        out_ready = 1;
        if (cyc >= 2000) begin
            nvec++;
            nerr++;
            $display("FAIL dump_timeout busy still high after %0d cycles, required low", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) tick();
        nvec++;
        if ({input_ready, rd_valid, rd_data, out_valid, out_data, out_last, busy, err, frame_count} !== {1'b1, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            nerr++;
            $display("FAIL reset_outputs got ir=%b rv=%b rd=%h ov=%b od=%h ol=%b busy=%b err=%b fc=%h, required 1 0 0 0 0 0 0 0 0",
                     input_ready, rd_valid, rd_data, out_valid, out_data, out_last, busy, err, frame_count);
        end
        reset = 1;
        tick();
        nvec++;
        if (input_ready !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release got ir=%b busy=%b, required 1 0", input_ready, busy);
        end
    endtask

    task automatic test_fill(input logic [23:0] val);
        int w;
        int cnt;
        logic [31:0] ra;
        send_cmd(3'd3, 0, {8'hA5, val}, w);
        cnt = 0;
        while (!input_ready && cnt < 100) begin
            cnt++;
            tick();
        end
        for (int i = 0; i < N; i++) model_mem[i] = val;
        nvec++;
        if (cnt !== N) begin
            nerr++;
            $display("FAIL fill_ready_low got %0d cycles, required %0d", cnt, N);
        end
        ra = 5;
        for (int k = 0; k < 2; k++) begin
            send_cmd(3'd2, ra, 0, w);
            nvec++;
            if (rd_valid !== 1'b1 || rd_data !== model_mem[ra]) begin
                nerr++;
                $display("FAIL fill_read addr=%0d got v=%b d=%h, required v=1 d=%h", ra, rd_valid, rd_data, model_mem[ra]);
            end
            tick();
            nvec++;
            if (rd_valid !== 1'b0 || rd_data !== model_mem[ra]) begin
                nerr++;
                $display("FAIL read_pulse got v=%b d=%h, required v=0 d=%h", rd_valid, rd_data, model_mem[ra]);
            end
            ra = $urandom_range(0, N - 1);
        end
    endtask

    task automatic test_write_dump();
        int w;
        int bc;
        logic [31:0] ra;
        logic [23:0] rv;
        send_cmd(3'd1, 0, 32'h0011_2233, w);
        model_mem[0] = 24'h112233;
        send_cmd(3'd1, 7, 32'hFFAA_BBCC, w);
        model_mem[7] = 24'hAABBCC;
        for (int k = 0; k < 3; k++) begin
            ra = $urandom_range(1, N - 2);
            rv = 24'($urandom);
            send_cmd(3'd1, ra, {8'h00, rv}, w);
            model_mem[ra] = rv;
        end
        run_dump(0, bc);
        model_fc++;
        nvec++;
        if (bc !== 4 * N) begin
            nerr++;
            $display("FAIL dump_busy got %0d cycles, required %0d", bc, 4 * N);
        end
        nvec++;
        if (got_b.size() !== 3 * N) begin
            nerr++;
            $display("FAIL dump_count got %0d bytes, required %0d", got_b.size(), 3 * N);
        end
        for (int i = 0; i < got_b.size() && i < 3 * N; i++) begin
            nvec++;
            if (got_b[i] !== 8'((model_mem[i / 3] >> (16 - 8 * (i % 3))) & 24'hFF) || got_l[i] !== (i == 3 * N - 1)) begin
                nerr++;
                $display("FAIL dump_byte[%0d] got %h last=%b, required %h last=%b", i, got_b[i], got_l[i],
                         8'((model_mem[i / 3] >> (16 - 8 * (i % 3))) & 24'hFF), i == 3 * N - 1);
            end
        end
        nvec++;
        if (frame_count !== 16'(model_fc)) begin
            nerr++;
            $display("FAIL dump_frame_count got %0d, required %0d", frame_count, model_fc);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int bc;
        for (int i = 0; i < N; i++) begin
            model_mem[i] = 24'($urandom);
            send_cmd(3'd1, i, {8'h00, model_mem[i]}, w);
        end
        for (int r = 0; r < 2; r++) begin
            run_dump(1, bc);
            model_fc++;
            nvec++;
            if (got_b.size() !== 3 * N) begin
                nerr++;
                $display("FAIL bp_count got %0d bytes, required %0d", got_b.size(), 3 * N);
            end
            for (int i = 0; i < got_b.size() && i < 3 * N; i++) begin
                nvec++;
                if (got_b[i] !== 8'((model_mem[i / 3] >> (16 - 8 * (i % 3))) & 24'hFF) || got_l[i] !== (i == 3 * N - 1)) begin
                    nerr++;
                    $display("FAIL bp_byte[%0d] got %h last=%b, required %h last=%b", i, got_b[i], got_l[i],
                             8'((model_mem[i / 3] >> (16 - 8 * (i % 3))) & 24'hFF), i == 3 * N - 1);
                end
            end
            nvec++;
            if (frame_count !== 16'(model_fc)) begin
                nerr++;
                $display("FAIL bp_frame_count got %0d, required %0d", frame_count, model_fc);
            end
        end
    endtask

    task automatic test_errors();
        int w;
        reset_dut();
        send_cmd(3'd1, 8, 32'h00DE_AD01, w);
        nvec++;
        if (err !== 1'b1) begin
            nerr++;
            $display("FAIL err_write_oob got err=%b, required 1", err);
        end
        send_cmd(3'd2, 0, 0, w);
        nvec++;
        if (rd_data !== model_mem[0]) begin
            nerr++;
            $display("FAIL write_oob_alias got %h, required %h", rd_data, model_mem[0]);
        end
        reset_dut();
        send_cmd(3'd2, 32'hFFFF_FFFF, 0, w);
        nvec++;
        if (rd_valid !== 1'b1 || rd_data !== 24'h0 || err !== 1'b1) begin
            nerr++;
            $display("FAIL read_oob got v=%b d=%h err=%b, required v=1 d=0 err=1", rd_valid, rd_data, err);
        end
        reset_dut();
        nvec++;
        if (err !== 1'b0) begin
            nerr++;
            $display("FAIL err_cleared got %b, required 0", err);
        end
        send_cmd(3'd6, 0, 0, w);
        nvec++;
        if (w !== 0 || err !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL illegal_op got wait=%0d err=%b busy=%b, required 0 1 0", w, err, busy);
        end
        send_cmd(3'd0, 0, 0, w);
        send_cmd(3'd2, 3, 0, w);
        nvec++;
        if (err !== 1'b1 || rd_data !== model_mem[3]) begin
            nerr++;
            $display("FAIL err_sticky got err=%b d=%h, required err=1 d=%h", err, rd_data, model_mem[3]);
        end
    endtask

    task automatic test_busy_cmd();
        int w;
        logic [23:0] fv;
        logic [23:0] wv;
        logic [31:0] wa;
        fv = 24'($urandom);
        wv = ~fv;
        wa = $urandom_range(0, N - 1);
        send_cmd(3'd3, 0, {8'h00, fv}, w);
        send_cmd(3'd1, wa, {8'h00, wv}, w);
        for (int i = 0; i < N; i++) model_mem[i] = fv;
        model_mem[wa] = wv;
        nvec++;
        if (w !== N) begin
            nerr++;
            $display("FAIL busy_wait got %0d cycles, required %0d", w, N);
        end
        for (int i = 0; i < N; i++) begin
            send_cmd(3'd2, i, 0, w);
            nvec++;
            if (rd_data !== model_mem[i]) begin
                nerr++;
                $display("FAIL busy_readback addr=%0d got %h, required %h", i, rd_data, model_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int w;
        int cyc;
        reset_dut();
        send_cmd(3'd4, 0, 0, w);
        cyc = 0;
        while (cyc < 10 + int'($urandom_range(0, 8))) begin
            cyc++;
            tick();
        end
        while (!out_valid && cyc < 100) begin
            cyc++;
            tick();
        end
        reset = 0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_count !== 16'h0 || busy !== 1'b0 || input_ready !== 1'b1) begin
            nerr++;
            $display("FAIL mid_dump_reset got ov=%b ol=%b fc=%0d busy=%b ir=%b, required 0 0 0 0 1",
                     out_valid, out_last, frame_count, busy, input_ready);
        end
        tick();
        reset = 1;
        tick();
        model_fc = 0;
    endtask

    initial begin
        test_reset();
        test_fill(24'h00FF00);
        test_write_dump();
        test_backpressure();
        test_errors();
        test_busy_cmd();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
